sevenseg_scan_decoder: RTL and testbench
========================================

Name: sevenseg_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed hex 7-segment driver: watches the active-low anode strobes, segments a..g and dp, and rebuilds the 32-bit hex value plus the 8-bit decimal-point mask.
- Placed on the board next to the display driver (loopback self-check) or in benches as a display monitor.
- Filters scan glitches, decodes each segment pattern back to a nibble, and publishes a complete frame once all eight digits have been captured.

Parameters:
- STABLE_CYCLES, 4, consecutive identical input samples required before a digit capture (legal range 1..255).

Ports:
- clk  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-low reset
- anodes  in  8  digit strobes, active-low; bit k low selects digit k (nibble value[4k+3:4k])
- a,b,c,d,e,f,g  in  1 each  segment drives, active-low
- dp  in  1  decimal point drive, active-low
- value  out  32  last complete decoded frame
- dp_mask  out  8  dp state per digit from the last frame (1 = lit)
- frame_valid  out  1  one-cycle pulse when value/dp_mask update
- digit_seen  out  8  digits captured in the frame currently being assembled
- seg_error  out  1  sticky; an unmappable segment pattern was captured

Behaviour:
- Reset (reset==0 at a clk edge): value=0, dp_mask=0, frame_valid=0, digit_seen=0, seg_error=0, stability counter=0, shadow registers=0. Reset in mid-frame discards the partial frame.
- Inputs are registered once (sample stage). The first capture therefore occurs STABLE_CYCLES+1 cycles after the inputs settle.
- Stability filter:
  - Sample word = {anodes, a..g, dp}.
  - Counter clears to 1 when the sample differs from the previous sample; otherwise it increments, saturating at 255.
  - Capture fires exactly once per stable interval, on the cycle the counter reaches STABLE_CYCLES.
- Anode qualification at capture:
  - Exactly one bit low: capture digit k.
  - All high: blank, ignore.
  - Two or more low: ignore; no error raised.
- Decode, active-high segments abcdefg -> nibble:
  - 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc
  - 8=abcdefg, 9=abcfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg
  - Any other pattern, including all-off: seg_error<=1, digit not marked seen, shadow unchanged.
- Valid capture of digit k:
  - shadow nibble k <= decoded value; shadow dp bit k <= ~dp; digit_seen[k] <= 1.
  - Recapture of an already-seen digit overwrites it (latest wins).
- Frame completion:
  - Occurs on the cycle a valid capture makes digit_seen all ones, counting the capture in that same cycle.
  - On the next clk edge: value <= shadow including the new nibble; dp_mask <= shadow dp including the new bit; frame_valid=1 for exactly one cycle; digit_seen <= 0.
  - value and dp_mask change only at frame completion, never partially.
- Scan order is irrelevant: any order, with repeats, completes once all eight digits are seen.
- seg_error clears only on reset.

Test Plan:
- Reset release, static inputs all 1 (blank) for 100 cycles -> value=0, dp_mask=0, frame_valid never asserts, digit_seen=0.
- Scan digits 0..7 in order, 8 cycles each, encoding 0x89ABCDEF, dp lit on digit 2 only -> single frame_valid pulse after the digit-7 capture; value=0x89ABCDEF; dp_mask=0x04; digit_seen returns to 0.
- Digit 3 stable for only STABLE_CYCLES-1 cycles, then a 1-cycle segment glitch on digit 5 -> neither digit captured; digit_seen unchanged.
- Reverse-order scan 7..0 of 0x01234567, with digit 4 shown first as 0xF and later as 0x3 -> value=0x01234567 (latest wins), exactly one frame_valid pulse.
- Stable pattern with segments a+g only on digit 1 -> seg_error=1 and stays 1; digit_seen[1]=0. A following full valid scan still produces a frame, and seg_error remains 1.
- Two anodes low for 20 cycles, then reset asserted mid-frame after 5 valid digits -> no capture on the double strobe; after reset, digit_seen=0 and value=0; the next full scan produces a correct frame.

Source files
------------

// File: rtl/sevenseg_scan_decoder.sv
// Monitors a multiplexed active-low hex 7-segment display and rebuilds the
// shown 32-bit value and decimal-point mask, one full frame at a time.
module sevenseg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  anodes,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic        dp,
  output logic [31:0] value,
  output logic [7:0]  dp_mask,
  output logic        frame_valid,
  output logic [7:0]  digit_seen,
  output logic        seg_error
);

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

  // Active-high abcdefg (a is MSB) to {ok, nibble}; ok=0 for unmappable patterns.
  function automatic logic [4:0] seg_decode(input logic [6:0] segs);
    logic [4:0] res;
    case (segs)
      7'h7E:   res = 5'h10;
      7'h30:   res = 5'h11;
      7'h6D:   res = 5'h12;
      7'h79:   res = 5'h13;
      7'h33:   res = 5'h14;
      7'h5B:   res = 5'h15;
      7'h5F:   res = 5'h16;
      7'h70:   res = 5'h17;
      7'h7F:   res = 5'h18;
      7'h73:   res = 5'h19;
      7'h77:   res = 5'h1A;
      7'h1F:   res = 5'h1B;
      7'h4E:   res = 5'h1C;
      7'h3D:   res = 5'h1D;
      7'h4F:   res = 5'h1E;
      7'h47:   res = 5'h1F;
      default: res = 5'h00;
    endcase
    return res;
  endfunction

  logic [15:0] in_s;
  logic [15:0] sample_r;
  logic [7:0]  cnt_r;
  logic        fired_r;
  logic [31:0] shadow_r;
  logic [7:0]  shdp_r;

  logic [7:0]  sel_s;
  logic        one_low_s;
  logic [2:0]  idx_s;
  logic [4:0]  dec_s;
  logic        capture_s;
  logic        cap_ok_s;
  logic        bad_s;
  logic        complete_s;
  logic [31:0] shadow_nx_s;
  logic [7:0]  shdp_nx_s;
  logic [7:0]  seen_nx_s;

  assign in_s = {anodes, a, b, c, d, e, f, g, dp};

  // Sample stage and stability counter; fired_r keeps a saturated count from re-capturing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sample_r <= 16'h0000;
      cnt_r    <= 8'd0;
      fired_r  <= 1'b0;
    end else begin
      sample_r <= in_s;
      if (in_s != sample_r) begin
        cnt_r   <= 8'd1;
        fired_r <= 1'b0;
      end else begin
        if (cnt_r != 8'hFF) begin
          cnt_r <= cnt_r + 8'd1;
        end else begin
          cnt_r <= cnt_r;
        end
        fired_r <= fired_r | capture_s;
      end
    end
  end

  // Anode qualification, decode and next shadow / seen state.
  always_comb begin
    sel_s       = ~sample_r[15:8];
    one_low_s   = 1'b1;
    idx_s       = 3'd0;
    dec_s       = seg_decode(~sample_r[7:1]);
    capture_s   = (cnt_r == STABLE_LIM) && !fired_r;
    shadow_nx_s = shadow_r;
    shdp_nx_s   = shdp_r;
    seen_nx_s   = digit_seen;
    case (sel_s)
      8'b0000_0001: idx_s = 3'd0;
      8'b0000_0010: idx_s = 3'd1;
      8'b0000_0100: idx_s = 3'd2;
      8'b0000_1000: idx_s = 3'd3;
      8'b0001_0000: idx_s = 3'd4;
      8'b0010_0000: idx_s = 3'd5;
      8'b0100_0000: idx_s = 3'd6;
      8'b1000_0000: idx_s = 3'd7;
      default:      one_low_s = 1'b0;
    endcase
    cap_ok_s = capture_s && one_low_s && dec_s[4];
    bad_s    = capture_s && one_low_s && !dec_s[4];
    if (cap_ok_s) begin
      shadow_nx_s[{idx_s, 2'b00} +: 4] = dec_s[3:0];
      shdp_nx_s[idx_s]                 = ~sample_r[0];
      seen_nx_s                        = digit_seen | sel_s;
    end else begin
      seen_nx_s = digit_seen;
    end
    complete_s = cap_ok_s && (seen_nx_s == 8'hFF);
  end

  // Shadow capture and whole-frame publication.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_r    <= 32'h0;
      shdp_r      <= 8'h00;
      value       <= 32'h0;
      dp_mask     <= 8'h00;
      frame_valid <= 1'b0;
      digit_seen  <= 8'h00;
      seg_error   <= 1'b0;
    end else begin
      shadow_r    <= shadow_nx_s;
      shdp_r      <= shdp_nx_s;
      frame_valid <= complete_s;
      seg_error   <= seg_error | bad_s;
      if (complete_s) begin
        value      <= shadow_nx_s;
        dp_mask    <= shdp_nx_s;
        digit_seen <= 8'h00;
      end else begin
        value      <= value;
        dp_mask    <= dp_mask;
        digit_seen <= seen_nx_s;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed bench for sevenseg_scan_decoder: drives scan patterns and checks
// rebuilt frames against hand-computed values.
module tb_sevenseg_scan_decoder;

  logic        clk;
  logic        reset;
  logic [7:0]  anodes;
  logic        a, b, c, d, e, f, g, dp;
  logic [31:0] value;
  logic [7:0]  dp_mask;
  logic        frame_valid;
  logic [7:0]  digit_seen;
  logic        seg_error;

  int checks   = 0;
  int failures = 0;
  int fv_cycles = 0;

  // Active-high abcdefg patterns for hex digits 0..F, a is MSB.
  logic [6:0] seg_pat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  sevenseg_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .anodes(anodes),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
    .value(value), .dp_mask(dp_mask), .frame_valid(frame_valid),
    .digit_seen(digit_seen), .seg_error(seg_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cycles++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive_raw(input logic [7:0] an, input logic [6:0] segs, input logic dp_on, input int n);
    anodes = an;
    {a, b, c, d, e, f, g} = ~segs;
    dp = ~dp_on;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic blank(input int n);
    drive_raw(8'hFF, 7'h00, 1'b0, n);
  endtask

  task automatic show_digit(input int k, input logic [3:0] nib, input logic dp_on, input int n);
    logic [7:0] one;
    one = 8'd1;
    drive_raw(~(one << k), seg_pat[nib], dp_on, n);
  endtask

  task automatic scan(input logic [31:0] val, input logic [7:0] dpm);
    for (int k = 0; k < 8; k++) show_digit(k, val[4*k +: 4], dpm[k], 8);
    blank(4);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    anodes = 8'hFF;
    {a, b, c, d, e, f, g, dp} = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_value", value, 32'h0);
    check_eq("rst_dp_mask", {24'h0, dp_mask}, 32'h0);
    check_eq("rst_fv", {31'h0, frame_valid}, 32'h0);
    check_eq("rst_seen", {24'h0, digit_seen}, 32'h0);
    check_eq("rst_err", {31'h0, seg_error}, 32'h0);
    reset = 1'b1;

    // Idle blank display
    blank(100);
    check_eq("idle_value", value, 32'h0);
    check_eq("idle_seen", {24'h0, digit_seen}, 32'h0);
    check_eq("idle_fv", fv_cycles, 32'd0);

    // In-order scan of 0x89ABCDEF, dp on digit 2
    for (int k = 0; k < 7; k++) show_digit(k, 4'(32'h89ABCDEF >> (4*k)), (k == 2), 8);
    check_eq("s1_partial_seen", {24'h0, digit_seen}, 32'h7F);
    check_eq("s1_partial_value", value, 32'h0);
    check_eq("s1_partial_fv", fv_cycles, 32'd0);
    show_digit(7, 4'h8, 1'b0, 8);
    blank(4);
    check_eq("s1_value", value, 32'h89ABCDEF);
    check_eq("s1_dp_mask", {24'h0, dp_mask}, 32'h04);
    check_eq("s1_seen", {24'h0, digit_seen}, 32'h0);
    check_eq("s1_fv", fv_cycles, 32'd1);
    check_eq("s1_err", {31'h0, seg_error}, 32'h0);

    // Short-lived digit 3 then a one-cycle glitch on digit 5
    blank(10);
    show_digit(3, 4'h5, 1'b0, 3);
    drive_raw(8'hDF, 7'h08, 1'b0, 1);
    blank(20);
    check_eq("glitch_seen", {24'h0, digit_seen}, 32'h0);
    check_eq("glitch_err", {31'h0, seg_error}, 32'h0);

    // Reverse scan of 0x01234567, digit 4 first shown as F then as 3
    show_digit(4, 4'hF, 1'b0, 8);
    for (int k = 7; k >= 0; k--) begin
      show_digit(k, 4'(32'h01234567 >> (4*k)), 1'b0, 8);
      if (k == 1) begin
        check_eq("s2_partial_value", value, 32'h89ABCDEF);
      end
    end
    blank(4);
    check_eq("s2_value", value, 32'h01234567);
    check_eq("s2_dp_mask", {24'h0, dp_mask}, 32'h00);
    check_eq("s2_fv", fv_cycles, 32'd2);

    // Unmappable a+g on digit 1
    drive_raw(8'hFD, 7'h41, 1'b0, 8);
    blank(4);
    check_eq("bad_err", {31'h0, seg_error}, 32'h1);
    check_eq("bad_seen", {24'h0, digit_seen}, 32'h0);
    scan(32'h13579BDF, 8'h81);
    check_eq("s3_value", value, 32'h13579BDF);
    check_eq("s3_dp_mask", {24'h0, dp_mask}, 32'h81);
    check_eq("s3_err_sticky", {31'h0, seg_error}, 32'h1);
    check_eq("s3_fv", fv_cycles, 32'd3);

    // Double strobe, then reset during a partial frame
    drive_raw(8'hF3, seg_pat[6], 1'b0, 20);
    blank(4);
    check_eq("dbl_seen", {24'h0, digit_seen}, 32'h0);
    for (int k = 0; k < 5; k++) show_digit(k, 4'(k + 1), 1'b0, 8);
    check_eq("pre_rst_seen", {24'h0, digit_seen}, 32'h1F);
    do_reset(2);
    check_eq("mid_rst_seen", {24'h0, digit_seen}, 32'h0);
    check_eq("mid_rst_value", value, 32'h0);
    check_eq("mid_rst_err", {31'h0, seg_error}, 32'h0);
    blank(4);
    scan(32'h2468ACE0, 8'h20);
    check_eq("s4_value", value, 32'h2468ACE0);
    check_eq("s4_dp_mask", {24'h0, dp_mask}, 32'h20);
    check_eq("s4_fv", fv_cycles, 32'd4);
    check_eq("s4_seen", {24'h0, digit_seen}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
